// File: rtl/sound_pkg.sv
// sound_pkg -- shared definitions for the sound-effect arbiter.
//
// Holds the arbiter state enum, the sound-effect id constants and the
// per-effect sample ROM layout (base address and length in samples).
// Lookup helpers return safe values for ids outside the table, so a
// wider NUM_SFX never indexes past the table or underflows a length.
package sound_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_PLAY   = 2'd2,
    ST_FINISH = 2'd3
  } sound_state_e;

  localparam int SFX_JUMP    = 0;
  localparam int SFX_SPRING  = 1;
  localparam int SFX_FALL    = 2;
  localparam int SFX_MONSTER = 3;

  localparam int SFX_COUNT = 4;

  localparam int SFX_BASE [SFX_COUNT] = '{0, 3000, 9000, 21000};
  localparam int SFX_LEN  [SFX_COUNT] = '{3000, 6000, 12000, 8000};

  // First ROM address of an effect; unknown ids map to address 0.
  function automatic int sfx_base(input int id);
    case (id)
      SFX_JUMP:    return SFX_BASE[SFX_JUMP];
      SFX_SPRING:  return SFX_BASE[SFX_SPRING];
      SFX_FALL:    return SFX_BASE[SFX_FALL];
      SFX_MONSTER: return SFX_BASE[SFX_MONSTER];
      default:     return 0;
    endcase
  endfunction

  // Length in samples; unknown ids play a single sample so LEN-1 never wraps.
  function automatic int sfx_len(input int id);
    case (id)
      SFX_JUMP:    return SFX_LEN[SFX_JUMP];
      SFX_SPRING:  return SFX_LEN[SFX_SPRING];
      SFX_FALL:    return SFX_LEN[SFX_FALL];
      SFX_MONSTER: return SFX_LEN[SFX_MONSTER];
      default:     return 1;
    endcase
  endfunction

  // True when every effect ends inside an n-bit address space.
  function automatic bit sfx_table_fits(input int n);
    longint limit;
    limit = longint'(1) << n;
    for (int i = 0; i < SFX_COUNT; i++) begin
      if (longint'(SFX_BASE[i]) + longint'(SFX_LEN[i]) > limit) return 1'b0;
    end
    return 1'b1;
  endfunction

endpackage

// File: rtl/sfx_priority_enc.sv
// sfx_priority_enc -- combinational lowest-index-first priority encoder.
//
// Ports:
//   req_i   [NUM_SFX]          request / pending vector, bit 0 highest priority
//   idx_o   [$clog2(NUM_SFX)]  index of the lowest set bit (0 when none)
//   valid_o                    high when any bit of req_i is set
module sfx_priority_enc #(
  parameter int NUM_SFX = 4
) (
  input  logic [NUM_SFX-1:0]         req_i,
  output logic [$clog2(NUM_SFX)-1:0] idx_o,
  output logic                       valid_o
);

  localparam int IW = $clog2(NUM_SFX);

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    // Walk from the top down so the lowest set index is the one that sticks.
    for (int i = NUM_SFX - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IW'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sound_arbiter.sv
// sound_arbiter -- arbitrates sound-effect requests onto one sample ROM.
//
// Each requester owns a one-deep pending flag. When idle and not muted the
// lowest pending index is granted; the effect's samples are then walked
// through the shared ROM address, one per Sound_clk cycle.
//
// Ports:
//   Sound_clk  sample clock, rising edge only
//   Reset      synchronous active-high reset
//   Req        per-effect play request (sets the pending flag)
//   Mute       blocks new grants and aborts START/PLAY without Done
//   Addr       shared sample ROM address
//   Sample_en  high while Addr carries a sample to output
//   Busy       high whenever the arbiter is not idle
//   Active_id  index of the most recently granted effect
//   Done       one-cycle completion pulse on the finished effect's bit
//
// Build option:
//   SOUND_PREEMPT_EN  when defined, a pending lower-index effect interrupts
//                     a playing one (no Done, interrupted effect dropped).
module sound_arbiter
  import sound_pkg::*;
#(
  parameter int N       = 16,
  parameter int NUM_SFX = 4
) (
  input  logic                       Sound_clk,
  input  logic                       Reset,
  input  logic [NUM_SFX-1:0]         Req,
  input  logic                       Mute,
  output logic [N-1:0]               Addr,
  output logic                       Sample_en,
  output logic                       Busy,
  output logic [$clog2(NUM_SFX)-1:0] Active_id,
  output logic [NUM_SFX-1:0]         Done
);

  localparam int IW = $clog2(NUM_SFX);

  sound_state_e       state_q,     state_d;
  logic [NUM_SFX-1:0] pending_q,   pending_d;
  logic [N-1:0]       addr_q,      addr_d;
  logic [N-1:0]       cnt_q,       cnt_d;
  logic [IW-1:0]      id_q,        id_d;
  logic               sample_en_q, sample_en_d;
  logic               busy_q,      busy_d;
  logic [NUM_SFX-1:0] done_q,      done_d;

  logic [IW-1:0]      enc_idx;
  logic               enc_valid;
  logic [NUM_SFX-1:0] grant_mask;
  logic [N-1:0]       base_cur;
  logic [N-1:0]       last_cnt;

  sfx_priority_enc #(
    .NUM_SFX (NUM_SFX)
  ) u_enc (
    .req_i   (pending_q),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  assign base_cur = N'(sfx_base(int'(id_q)));
  assign last_cnt = N'(sfx_len(int'(id_q)) - 1);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    sample_en_d = 1'b0;
    done_d      = '0;
    grant_mask  = '0;

    case (state_q)
      ST_IDLE: begin
        if (!Mute && enc_valid) begin
          grant_mask[enc_idx] = 1'b1;
          id_d                = enc_idx;
          state_d             = ST_START;
        end
      end

      ST_START: begin
        if (Mute) begin
          state_d = ST_IDLE;
        end else begin
          addr_d      = base_cur;
          cnt_d       = '0;
          sample_en_d = 1'b1;
          state_d     = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (Mute) begin
          state_d = ST_IDLE;
`ifdef SOUND_PREEMPT_EN
        end else if (enc_valid && (enc_idx < id_q)) begin
          // Higher-priority effect takes over; the current one is dropped.
          grant_mask[enc_idx] = 1'b1;
          id_d                = enc_idx;
          state_d             = ST_START;
`endif
        end else if (cnt_q == last_cnt) begin
          // Last sample is on Addr now; hold it through FINISH.
          done_d[id_q] = 1'b1;
          state_d      = ST_FINISH;
        end else begin
          addr_d      = addr_q + N'(1);
          cnt_d       = cnt_q + N'(1);
          sample_en_d = 1'b1;
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A request landing on the same edge as its grant re-arms the flag.
    pending_d = (pending_q & ~grant_mask) | Req;
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge Sound_clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      id_q        <= '0;
      sample_en_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      sample_en_q <= sample_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign Addr      = addr_q;
  assign Sample_en = sample_en_q;
  assign Busy      = busy_q;
  assign Active_id = id_q;
  assign Done      = done_q;

endmodule

// File: tb/tb_sound_arbiter.sv
// tb_sound_arbiter -- self-checking bench for sound_arbiter.
// Honours SOUND_PREEMPT_EN the same way the design does.
module tb_sound_arbiter;
  import sound_pkg::*;

  localparam int N  = 16;
  localparam int NS = 4;

  logic        Sound_clk = 1'b0;
  logic        Reset     = 1'b1;
  logic [3:0]  Req       = 4'b0000;
  logic        Mute      = 1'b0;
  logic [15:0] Addr;
  logic        Sample_en;
  logic        Busy;
  logic [1:0]  Active_id;
  logic [3:0]  Done;

  sound_arbiter #(.N(N), .NUM_SFX(NS)) dut (
    .Sound_clk (Sound_clk),
    .Reset     (Reset),
    .Req       (Req),
    .Mute      (Mute),
    .Addr      (Addr),
    .Sample_en (Sample_en),
    .Busy      (Busy),
    .Active_id (Active_id),
    .Done      (Done)
  );

  always #5 Sound_clk = ~Sound_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int model_prints = 0;

  initial assert (sfx_table_fits(N)) else $error("sound ROM table exceeds the %0d-bit address space", N);

  // ---------------- reference model (sample-phase based) ----------------
  function automatic int base_of(input int i);
    case (i)
      0: return 0;
      1: return 3000;
      2: return 9000;
      default: return 21000;
    endcase
  endfunction

  function automatic int len_of(input int i);
    case (i)
      0: return 3000;
      1: return 6000;
      2: return 12000;
      default: return 8000;
    endcase
  endfunction

  function automatic int lowest(input logic [3:0] p);
    for (int i = 0; i < 4; i++) if (p[i]) return i;
    return -1;
  endfunction

  logic [3:0] m_pend = '0;
  bit         m_play = 0;
  int         m_id   = 0;
  int         m_k    = 0;   // 0 = setup cycle, 1..LEN = sample k-1, LEN+1 = done cycle
  int         m_addr = 0;

  task automatic model_step(input logic [3:0] r, input logic m, input logic rs);
    int j;
    if (rs) begin
      m_pend = '0; m_play = 0; m_id = 0; m_k = 0; m_addr = 0;
    end else begin
      j = lowest(m_pend);
      if (!m_play) begin
        if (!m && j >= 0) begin
          m_pend[j] = 1'b0; m_play = 1; m_id = j; m_k = 0;
        end
      end else if (m_k == 0) begin
        if (m) m_play = 0;
        else begin m_k = 1; m_addr = base_of(m_id); end
      end else if (m_k <= len_of(m_id)) begin
        if (m) m_play = 0;
`ifdef SOUND_PREEMPT_EN
        else if (j >= 0 && j < m_id) begin
          m_pend[j] = 1'b0; m_id = j; m_k = 0;
        end
`endif
        else begin
          m_k++;
          if (m_k <= len_of(m_id)) m_addr = base_of(m_id) + m_k - 1;
        end
      end else begin
        m_play = 0;
      end
      m_pend |= r;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model();
    logic [23:0] act, exp;
    logic        e_sen;
    logic [3:0]  e_done;
    e_sen  = m_play && m_k >= 1 && m_k <= len_of(m_id);
    e_done = (m_play && m_k == len_of(m_id) + 1) ? (4'b0001 << m_id) : 4'b0000;
    act = {Busy, Sample_en, Done, Active_id, Addr};
    exp = {m_play, e_sen, e_done, 2'(m_id), 16'(m_addr)};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (model_prints < 20) begin
        model_prints++;
        $display("FAIL model @%0t: got %h expected %h (busy,en,done,id,addr)", $time, act, exp);
      end
    end
  endtask

  task automatic tick(input logic [3:0] r, input logic m, input logic rs);
    Req = r; Mute = m; Reset = rs;
    @(posedge Sound_clk);
    model_step(r, m, rs);
    #1;
    check_model();
  endtask

  // Runs with idle inputs until the arbiter has been busy and returned to idle.
  task automatic play_out(output int cyc, output int n_en, output int first_a,
                          output int last_a, output logic [3:0] done_acc, output int n_done);
    bit started = 0;
    bit ended   = 0;
    cyc = 0; n_en = 0; first_a = -1; last_a = -1; done_acc = '0; n_done = 0;
    while (!ended && cyc < 20000) begin
      tick(4'b0000, 1'b0, 1'b0);
      cyc++;
      if (Sample_en) begin
        if (n_en == 0) first_a = Addr;
        last_a = Addr;
        n_en++;
      end
      if (Done != 4'b0000) begin done_acc |= Done; n_done++; end
      if (Busy) started = 1;
      else if (started) ended = 1;
    end
    if (!ended) begin
      n_cmp++; n_bad++;
      $display("FAIL play_out_timeout: got %0d cycles without returning idle, required under 20000", cyc);
    end
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic [3:0]  req;
    logic        mute;
    logic        rst;
    logic        busy;
    logic        sen;
    logic [15:0] addr;
    logic [3:0]  done;
    logic [1:0]  id;
  } vec_t;

  vec_t tbl [19];

  int cyc, n_en, fa, la, nd;
  logic [3:0] dacc;
  logic [3:0] r;
  int mute_left;

  initial begin
    tbl[0]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0,    4'b0000, 2'd0};
    tbl[1]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0,    4'b0000, 2'd0};
    tbl[2]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0,    4'b0000, 2'd0};
    tbl[3]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0,    4'b0000, 2'd0};
    tbl[4]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1,    4'b0000, 2'd0};
    tbl[5]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2,    4'b0000, 2'd0};
    tbl[6]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2,    4'b0000, 2'd0};
    tbl[7]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2,    4'b0000, 2'd0};
    tbl[8]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2,    4'b0000, 2'd2};
    tbl[9]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'd9000, 4'b0000, 2'd2};
    tbl[10] = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'd9001, 4'b0000, 2'd2};
    tbl[11] = '{4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0,    4'b0000, 2'd0};
    tbl[12] = '{4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0,    4'b0000, 2'd0};
    tbl[13] = '{4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0,    4'b0000, 2'd1};
    tbl[14] = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0,    4'b0000, 2'd1};
    tbl[15] = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0,    4'b0000, 2'd1};
    tbl[16] = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'd3000, 4'b0000, 2'd1};
    tbl[17] = '{4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0,    4'b0000, 2'd0};
    tbl[18] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0,    4'b0000, 2'd0};

    repeat (2) @(posedge Sound_clk);
    #1;

    for (int i = 0; i < 19; i++) begin
      tick(tbl[i].req, tbl[i].mute, tbl[i].rst);
      check($sformatf("vec%0d", i),
            {Busy, Sample_en, Done, Active_id, Addr},
            {tbl[i].busy, tbl[i].sen, tbl[i].done, tbl[i].id, tbl[i].addr});
    end

    // Single effect 0 end to end.
    tick(4'b0000, 1'b0, 1'b1);
    tick(4'b0001, 1'b0, 1'b0);
    play_out(cyc, n_en, fa, la, dacc, nd);
    check("jump_en_count", n_en, 3000);
    check("jump_first",    fa, 0);
    check("jump_last",     la, 2999);
    check("jump_done",     dacc, 4'b0001);
    check("jump_done_n",   nd, 1);
    check("jump_idle",     Busy, 1'b0);

    // Two simultaneous requests, priority order and grant spacing.
    tick(4'b0000, 1'b0, 1'b1);
    tick(4'b0110, 1'b0, 1'b0);
    play_out(cyc, n_en, fa, la, dacc, nd);
    check("spring_cycles", cyc, 6003);
    check("spring_first",  fa, 3000);
    check("spring_last",   la, 8999);
    check("spring_done",   dacc, 4'b0010);
    play_out(cyc, n_en, fa, la, dacc, nd);
    check("fall_cycles",   cyc, 12003);
    check("fall_en_count", n_en, 12000);
    check("fall_first",    fa, 9000);
    check("fall_last",     la, 20999);
    check("fall_done",     dacc, 4'b0100);

    // Repeated requests for the playing effect collapse to one replay.
    tick(4'b0000, 1'b0, 1'b1);
    tick(4'b1000, 1'b0, 1'b0);
    tick(4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(4'b1000, 1'b0, 1'b0);
      tick(4'b0000, 1'b0, 1'b0);
      tick(4'b0000, 1'b0, 1'b0);
    end
    play_out(cyc, n_en, fa, la, dacc, nd);
    check("monster_last",  la, 28999);
    check("monster_done",  dacc, 4'b1000);
    play_out(cyc, n_en, fa, la, dacc, nd);
    check("replay_en_count", n_en, 8000);
    check("replay_first",  fa, 21000);
    check("replay_last",   la, 28999);
    check("replay_done_n", nd, 1);
    repeat (3) tick(4'b0000, 1'b0, 1'b0);
    check("no_second_replay", Busy, 1'b0);

    // Mute at sample 100 of effect 2.
    tick(4'b0000, 1'b0, 1'b1);
    tick(4'b0100, 1'b0, 1'b0);
    tick(4'b0000, 1'b0, 1'b0);
    tick(4'b0000, 1'b0, 1'b0);
    repeat (100) tick(4'b0000, 1'b0, 1'b0);
    check("mute_at_addr", Addr, 16'd9100);
    tick(4'b0000, 1'b1, 1'b0);
    check("mute_sample_en", Sample_en, 1'b0);
    check("mute_busy",      Busy, 1'b0);
    check("mute_done",      Done, 4'b0000);
    dacc = '0;
    repeat (3) begin tick(4'b0000, 1'b1, 1'b0); dacc |= Done; end
    tick(4'b0000, 1'b0, 1'b0);
    check("mute_no_done_later", {Busy, dacc}, 5'b0);

    // Reset at sample 50 with another effect pending.
    tick(4'b0000, 1'b0, 1'b1);
    tick(4'b0001, 1'b0, 1'b0);
    tick(4'b0000, 1'b0, 1'b0);
    tick(4'b0000, 1'b0, 1'b0);
    tick(4'b0100, 1'b0, 1'b0);
    repeat (49) tick(4'b0000, 1'b0, 1'b0);
    check("rst_at_addr", Addr, 16'd50);
    tick(4'b0000, 1'b0, 1'b1);
    check("rst_outputs", {Busy, Sample_en, Done, Active_id, Addr}, 24'h0);
    repeat (4) tick(4'b0000, 1'b0, 1'b0);
    check("rst_pending_cleared", Busy, 1'b0);

    // Higher-priority request during effect 2.
    tick(4'b0000, 1'b0, 1'b1);
    tick(4'b0100, 1'b0, 1'b0);
    tick(4'b0000, 1'b0, 1'b0);
    tick(4'b0000, 1'b0, 1'b0);
    repeat (10) tick(4'b0000, 1'b0, 1'b0);
    tick(4'b0001, 1'b0, 1'b0);
`ifdef SOUND_PREEMPT_EN
    tick(4'b0000, 1'b0, 1'b0);
    check("preempt_start", {Busy, Sample_en, Done, Active_id}, {1'b1, 1'b0, 4'b0000, 2'd0});
    tick(4'b0000, 1'b0, 1'b0);
    check("preempt_addr", {Sample_en, Addr}, {1'b1, 16'd0});
    play_out(cyc, n_en, fa, la, dacc, nd);
    check("preempt_done", dacc, 4'b0001);
    check("preempt_last", la, 2999);
    repeat (3) tick(4'b0000, 1'b0, 1'b0);
    check("preempt_not_requeued", Busy, 1'b0);
`else
    play_out(cyc, n_en, fa, la, dacc, nd);
    check("nopreempt_done", dacc, 4'b0100);
    check("nopreempt_last", la, 20999);
    play_out(cyc, n_en, fa, la, dacc, nd);
    check("nopreempt_next_first", fa, 0);
    check("nopreempt_next_done",  dacc, 4'b0001);
`endif

    // Randomized traffic against the reference model.
    tick(4'b0000, 1'b0, 1'b1);
    mute_left = 0;
    for (int i = 0; i < 15000; i++) begin
      r = '0;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 299) == 0) r[b] = 1'b1;
      if (mute_left > 0) mute_left--;
      else if ($urandom_range(0, 1999) == 0) mute_left = $urandom_range(1, 20);
      tick(r, mute_left > 0, $urandom_range(0, 7999) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
